// File: rtl/snoop_dispatch_pkg.sv
// snoop_dispatch_pkg
// Shared definitions for the snooper dispatcher.
// Contents:
//   state_e         - dispatcher FSM encoding (idle / stream / finish)
//   sel_width()     - select width for an N-entry VM array (minimum 1 bit)
//   NVmsDefault     - default VM count
//   SelWidthDefault - select width for the default VM count
package snoop_dispatch_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStream = 2'd1,
      StFinish = 2'd2
   } state_e;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned NVmsDefault     = 4;
   localparam int unsigned SelWidthDefault = sel_width(NVmsDefault);

endpackage

// File: rtl/snoop_dispatch_if.sv
// snoop_dispatch_if
// Bundles the upstream snooper bus and the broadcast VM-side bus.
// Upstream: up_wr_addr, up_wr_data, up_wr_en, up_done (to dispatcher), up_ready (from it).
// VM side:  vm_wr_addr, vm_wr_data, vm_wr_en, vm_done (from dispatcher), vm_ready (to it).
// Modports: master = snooper / VM array side, slave = dispatcher side.
interface snoop_dispatch_if #(
   parameter int unsigned N_VMS                = 4,
   parameter int unsigned SNOOP_FWD_ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH           = 64
);
   logic [SNOOP_FWD_ADDR_WIDTH-1:0] up_wr_addr;
   logic [DATA_WIDTH-1:0]           up_wr_data;
   logic                            up_wr_en;
   logic                            up_done;
   logic                            up_ready;

   logic [SNOOP_FWD_ADDR_WIDTH-1:0] vm_wr_addr;
   logic [DATA_WIDTH-1:0]           vm_wr_data;
   logic [N_VMS-1:0]                vm_wr_en;
   logic [N_VMS-1:0]                vm_done;
   logic [N_VMS-1:0]                vm_ready;

   modport master (
      output up_wr_addr, up_wr_data, up_wr_en, up_done, vm_ready,
      input  up_ready, vm_wr_addr, vm_wr_data, vm_wr_en, vm_done
   );

   modport slave (
      input  up_wr_addr, up_wr_data, up_wr_en, up_done, vm_ready,
      output up_ready, vm_wr_addr, vm_wr_data, vm_wr_en, vm_done
   );
endinterface

// File: rtl/snoop_dispatch_rr_pick.sv
// rr_pick
// Combinational circular priority picker: returns the first set bit of req at or after
// ptr, wrapping from N_VMS-1 back to 0.
// Ports:
//   req   in  N_VMS - request vector
//   ptr   in  SEL_W - search start index (must be < N_VMS)
//   idx   out SEL_W - selected index (0 when nothing requested)
//   valid out 1     - at least one request bit is set
module rr_pick
   import snoop_dispatch_pkg::*;
#(
   parameter int unsigned N_VMS = 4,
   localparam int unsigned SEL_W = sel_width(N_VMS)
) (
   input  logic [N_VMS-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             valid
);

   int               cand;
   logic [SEL_W-1:0] cand_idx;

   always_comb begin
      idx      = '0;
      valid    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < int'(N_VMS); i++) begin
         cand     = (int'(ptr) + i) % int'(N_VMS);
         cand_idx = SEL_W'(cand);
         if (!valid && req[cand_idx]) begin
            valid = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/snoop_dispatch.sv
// snoop_dispatch
// Round-robin dispatcher sharing one upstream packet snooper among N_VMS bpfvm instances.
// A packet is granted to the next ready VM, its beats are registered and forwarded to that
// VM only, and a single-cycle done pulse closes it.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   bus (slave)     - upstream snooper bus plus broadcast VM bus (see snoop_dispatch_if)
//   grant_idx       - index of the current or most recently granted VM
//   pkt_count       - packets dispatched, wraps modulo 2^32
//   err_wr_unready  - sticky: a write arrived while no VM was granted
module snoop_dispatch
   import snoop_dispatch_pkg::*;
#(
   parameter int unsigned N_VMS                = 4,
   parameter int unsigned SNOOP_FWD_ADDR_WIDTH = 9,
   parameter int unsigned DATA_WIDTH           = 64,
   localparam int unsigned SEL_W = sel_width(N_VMS)
) (
   input  logic             clk,
   input  logic             rst,
   snoop_dispatch_if.slave  bus,
   output logic [SEL_W-1:0] grant_idx,
   output logic [31:0]      pkt_count,
   output logic             err_wr_unready
);

   state_e                          state_q, state_d;
   logic [SEL_W-1:0]                grant_q, grant_d;
   logic [SEL_W-1:0]                rr_ptr_q, rr_ptr_d;
   logic [31:0]                     pkt_count_q, pkt_count_d;
   logic                            err_q, err_d;
   logic [SNOOP_FWD_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]           data_q, data_d;
   logic [N_VMS-1:0]                wr_en_q, wr_en_d;

   logic [N_VMS-1:0] grant_onehot;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_valid;

   rr_pick #(
      .N_VMS (N_VMS)
   ) u_rr_pick (
      .req   (bus.vm_ready),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      grant_onehot          = '0;
      grant_onehot[grant_q] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      pkt_count_d = pkt_count_q;
      err_d       = err_q;
      addr_d      = addr_q;
      data_d      = data_q;
      wr_en_d     = '0;

      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = StStream;
            end
         end
         StStream: begin
            // A beat coinciding with up_done is still forwarded.
            if (bus.up_wr_en) begin
               wr_en_d = grant_onehot;
               addr_d  = bus.up_wr_addr;
               data_d  = bus.up_wr_data;
            end
            if (bus.up_done) begin
               state_d = StFinish;
            end
         end
         StFinish: begin
            pkt_count_d = pkt_count_q + 32'd1;
            rr_ptr_d    = (grant_q == SEL_W'(N_VMS - 1)) ? '0 : grant_q + SEL_W'(1);
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Beats outside STREAM are dropped and flagged until reset.
      if (bus.up_wr_en && (state_q != StStream)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         pkt_count_q <= '0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         wr_en_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         pkt_count_q <= pkt_count_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         wr_en_q     <= wr_en_d;
      end
   end

   // FINISH lasts exactly one cycle, so decoding done from state gives a one-cycle pulse.
   assign bus.up_ready   = (state_q == StStream);
   assign bus.vm_done    = (state_q == StFinish) ? grant_onehot : '0;
   assign bus.vm_wr_en   = wr_en_q;
   assign bus.vm_wr_addr = addr_q;
   assign bus.vm_wr_data = data_q;

   assign grant_idx      = grant_q;
   assign pkt_count      = pkt_count_q;
   assign err_wr_unready = err_q;

endmodule
